// File: rtl/pg_pkg.sv
// -----------------------------------------------------------------------------
// pg_pkg
// Shared definitions for the pattern generator: playback state encoding,
// bit positions inside a pattern word and the "released" line value.
// -----------------------------------------------------------------------------
package pg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_FIN   = 2'd3
    } pg_state_e;

    // Pattern word layout
    localparam int SCL_LSB  = 0;   // [2:0]  line enables
    localparam int FLAG_BIT = 30;  // [30]   input-expecting flag
    localparam int LAST_BIT = 31;  // [31]   last-word marker

    // All three lines released (open-drain: 1 = not driven)
    localparam logic [2:0] SCL_RELEASED = 3'b111;

endpackage

// File: rtl/pg_pattern_ram.sv
// -----------------------------------------------------------------------------
// pg_pattern_ram
// Simple dual-port pattern buffer: one write port, one synchronous read port
// with one cycle of latency. Contents have no reset so the array maps onto
// block RAM and survives a logic reset.
//
// Ports:
//   clk        clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (registered on the rising edge)
//   o_rd_data  read data, valid the cycle after the address is presented
// -----------------------------------------------------------------------------
module pg_pattern_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pattern_gen_scl.sv
// -----------------------------------------------------------------------------
// pattern_gen_scl
// Plays a stored sequence of 32-bit pattern words onto three open-drain
// lines. Each word is held for clk_div+1 clocks; pg_clk strobes on the first
// cycle of every word. Playback ends after num_words words or after the first
// word carrying the last-word marker, then pulses done.
//
// Optional feature (macro PG_CAPTURE_EN): captures scl_in[0] in the last
// cycle of every step whose flag bit is set, into cap_data (LSB first,
// saturating at 32 samples) with the sample count on cap_cnt.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/addr/data   pattern buffer write port (ignored while busy)
//   start, stop       begin / abort playback pulses (stop wins)
//   num_words         words to play (clamped to DEPTH), latched at start
//   clk_div           step length minus one, latched at start
//   busy, done        playback active / one-cycle completion pulse
//   pg_clk            one-cycle strobe when a new word is presented
//   pg_scl, pg_bit30  current word line enables and flag
//   scl_in            sampled line levels (used only with capture)
//   cap_data, cap_cnt capture result (PG_CAPTURE_EN only)
// -----------------------------------------------------------------------------
module pattern_gen_scl
    import pg_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DIV_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic [AW:0]      num_words,
    input  logic [DIV_W-1:0] clk_div,
    output logic             busy,
    output logic             done,
    output logic             pg_clk,
    output logic [2:0]       pg_scl,
    output logic             pg_bit30,
    input  logic [2:0]       scl_in
`ifdef PG_CAPTURE_EN
    ,
    output logic [31:0]      cap_data,
    output logic [5:0]       cap_cnt
`endif
);

    localparam logic [AW:0] NUM_MAX = (AW+1)'(DEPTH);

    pg_state_e        r_state, r_state_next;
    logic [AW-1:0]    r_idx, r_idx_next;
    logic [AW:0]      r_num, r_num_next;
    logic [DIV_W-1:0] r_div, r_div_next;
    logic [DIV_W-1:0] r_div_cnt, r_div_cnt_next;
    logic             r_last, r_last_next;
    logic             r_busy, r_busy_next;
    logic             r_done, r_done_next;
    logic             r_pg_clk, r_pg_clk_next;
    logic [2:0]       r_pg_scl, r_pg_scl_next;
    logic             r_pg_bit30, r_pg_bit30_next;

    logic [31:0]      w_rd_data;
    logic [AW-1:0]    w_rd_addr;
    logic             w_start_ok;
    logic [AW:0]      w_num_clamped;

    assign w_start_ok    = (r_state == ST_IDLE) && start && !stop;
    assign w_num_clamped = (num_words > NUM_MAX) ? NUM_MAX : num_words;

    // The RAM registers the address of the word that follows the one about
    // to be shown, so it is already on w_rd_data when the current step ends,
    // even for one-cycle steps.
    assign w_rd_addr = (r_state_next == ST_FETCH) ? '0 : r_idx_next + AW'(1);

    pg_pattern_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (wr_en && !r_busy),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        r_state_next    = r_state;
        r_idx_next      = r_idx;
        r_num_next      = r_num;
        r_div_next      = r_div;
        r_div_cnt_next  = r_div_cnt;
        r_last_next     = r_last;
        r_busy_next     = r_busy;
        r_done_next     = 1'b0;
        r_pg_clk_next   = 1'b0;
        r_pg_scl_next   = r_pg_scl;
        r_pg_bit30_next = r_pg_bit30;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    r_state_next = ST_FETCH;
                    r_busy_next  = 1'b1;
                    r_idx_next   = '0;
                    r_num_next   = w_num_clamped;
                    r_div_next   = clk_div;
                end
            end
            ST_FETCH: begin
                if (r_num == '0) begin
                    // Nothing to play: finish without ever driving the lines.
                    r_state_next = ST_FIN;
                    r_busy_next  = 1'b0;
                    r_done_next  = 1'b1;
                end else begin
                    r_state_next    = ST_RUN;
                    r_pg_clk_next   = 1'b1;
                    r_pg_scl_next   = w_rd_data[SCL_LSB +: 3];
                    r_pg_bit30_next = w_rd_data[FLAG_BIT];
                    r_div_cnt_next  = r_div;
                    r_last_next     = w_rd_data[LAST_BIT] || (r_num == (AW+1)'(1));
                end
            end
            ST_RUN: begin
                if (r_div_cnt != '0) begin
                    r_div_cnt_next = r_div_cnt - DIV_W'(1);
                end else if (r_last) begin
                    r_state_next    = ST_FIN;
                    r_busy_next     = 1'b0;
                    r_done_next     = 1'b1;
                    r_pg_scl_next   = SCL_RELEASED;
                    r_pg_bit30_next = 1'b0;
                end else begin
                    r_idx_next      = r_idx + AW'(1);
                    r_pg_clk_next   = 1'b1;
                    r_pg_scl_next   = w_rd_data[SCL_LSB +: 3];
                    r_pg_bit30_next = w_rd_data[FLAG_BIT];
                    r_div_cnt_next  = r_div;
                    r_last_next     = w_rd_data[LAST_BIT] ||
                                      (({1'b0, r_idx_next} + (AW+1)'(1)) == r_num);
                end
            end
            ST_FIN: begin
                r_state_next = ST_IDLE;
            end
            default: begin
                r_state_next = ST_IDLE;
            end
        endcase

        // Abort: back to IDLE with the lines released and no done pulse.
        if (stop && r_busy) begin
            r_state_next    = ST_IDLE;
            r_busy_next     = 1'b0;
            r_done_next     = 1'b0;
            r_pg_clk_next   = 1'b0;
            r_pg_scl_next   = SCL_RELEASED;
            r_pg_bit30_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_num      <= '0;
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pg_clk   <= 1'b0;
            r_pg_scl   <= SCL_RELEASED;
            r_pg_bit30 <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_idx      <= r_idx_next;
            r_num      <= r_num_next;
            r_div      <= r_div_next;
            r_div_cnt  <= r_div_cnt_next;
            r_last     <= r_last_next;
            r_busy     <= r_busy_next;
            r_done     <= r_done_next;
            r_pg_clk   <= r_pg_clk_next;
            r_pg_scl   <= r_pg_scl_next;
            r_pg_bit30 <= r_pg_bit30_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign pg_clk   = r_pg_clk;
    assign pg_scl   = r_pg_scl;
    assign pg_bit30 = r_pg_bit30;

    // Word bits that carry no meaning for playback.
    logic w_unused_bits;
    assign w_unused_bits = ^w_rd_data[FLAG_BIT-1:SCL_LSB+3];

`ifdef PG_CAPTURE_EN
    logic [31:0] r_cap_data;
    logic [5:0]  r_cap_cnt;
    logic        w_cap_sample;

    // Last cycle of a flagged step that is not being aborted.
    assign w_cap_sample = (r_state == ST_RUN) && !stop && (r_div_cnt == '0) && r_pg_bit30;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_cap_data <= '0;
            r_cap_cnt  <= '0;
        end else if (w_cap_sample && (r_cap_cnt < 6'd32)) begin
            r_cap_data[r_cap_cnt[4:0]] <= scl_in[0];
            r_cap_cnt                  <= r_cap_cnt + 6'd1;
        end
    end

    assign cap_data = r_cap_data;
    assign cap_cnt  = r_cap_cnt;

    logic w_unused_scl;
    assign w_unused_scl = ^scl_in[2:1];
`else
    logic w_unused_scl;
    assign w_unused_scl = ^scl_in;
`endif

endmodule

// File: doc/pattern_gen_scl.md
PATTERN_GEN_SCL -- requirements
Module: pattern_gen_scl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the pattern buffer depth in 32-bit words (power of two).
REQ-002 SHALL have parameter DIV_W, default 16, meaning the step-divider width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: port `clk`, input, 1 bit, rising-edge clock; port `rst`, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have `wr_en`, input, 1 bit, buffer write strobe.
REQ-005 SHALL have `wr_addr`, input, log2(DEPTH) bits, buffer write address.
REQ-006 SHALL have `wr_data`, input, 32 bits, pattern word.
REQ-007 SHALL have `start`, input, 1 bit, begin playback pulse.
REQ-008 SHALL have `stop`, input, 1 bit, abort playback pulse.
REQ-009 SHALL have `num_words`, input, log2(DEPTH)+1 bits, words to play.
REQ-010 SHALL have `clk_div`, input, DIV_W bits, step length minus 1, in clk cycles.
REQ-011 SHALL have `busy`, output, 1 bit, playback active.
REQ-012 SHALL have `done`, output, 1 bit, one-cycle completion pulse.
REQ-013 SHALL have `pg_clk`, output, 1 bit, one-cycle step strobe.
REQ-014 SHALL have `pg_scl`, output, 3 bits, per-line tristate enable (1 = release, 0 = drive low).
REQ-015 SHALL have `pg_bit30`, output, 1 bit, input-expecting flag.
REQ-016 SHALL have `scl_in`, input, 3 bits, sampled line levels.

Function
REQ-017 SHALL decode each word as: [2:0] pg_scl value, [30] pg_bit30 value, [31] last-word marker, other bits ignored.
REQ-018 SHALL run a state machine with states IDLE -> FETCH (1-cycle buffer read) -> RUN -> FIN -> IDLE.
REQ-019 SHALL, on start in IDLE, assert busy the next cycle and present word 0 on pg_scl/pg_bit30 two cycles after start.
REQ-020 SHALL hold each word for clk_div+1 cycles; clk_div=0 SHALL give one word per cycle with no gap.
REQ-021 SHALL pulse pg_clk for one cycle in the first cycle each new word is presented.
REQ-022 SHALL end playback after word num_words-1 or after the first word with bit 31 set, whichever comes first, each held for its full step.
REQ-023 SHALL, in FIN, release outputs (pg_scl=3'b111, pg_bit30=0), deassert busy, and pulse done for one cycle.
REQ-024 SHALL treat num_words=0 as complete immediately: done pulses 2 cycles after start, pg_scl is never driven, pg_clk never pulses.
REQ-025 SHALL clamp num_words > DEPTH to DEPTH.
REQ-026 SHALL latch num_words and clk_div at start; later changes SHALL not affect the run in progress.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL, on stop while busy, return to IDLE the next cycle with outputs released and busy=0, with no done pulse.
REQ-029 SHALL resolve start and stop asserted in the same cycle in favour of stop; no playback starts.
REQ-030 SHALL drop buffer writes while busy; writes in IDLE SHALL take effect for the next start.

Reset
REQ-031 SHALL, while rst is high, force IDLE, busy=0, done=0, pg_clk=0, pg_scl=3'b111, pg_bit30=0, and all counters to 0.
REQ-032 SHALL preserve buffer contents across reset.
REQ-033 SHALL abort mid-run on reset exactly as stop does, with no done pulse.

Configuration
REQ-034 SHALL use macro PG_CAPTURE_EN to gate the capture feature.
REQ-035 SHALL, with PG_CAPTURE_EN defined, add `cap_data` (output, 32 bits, one bit per step, LSB first, saturating at 32) and `cap_cnt` (output, 6 bits), where scl_in[0] is sampled in the last cycle of every step with bit30=1.
REQ-036 SHALL clear cap_data/cap_cnt on start and on reset.
REQ-037 SHALL, without PG_CAPTURE_EN, omit those ports and leave scl_in unused.

Structure
REQ-038 SHALL place the state enum, word bit-position constants (SCL_LSB=0, FLAG_BIT=30, LAST_BIT=31), and the released value 3'b111 in shared package pg_pkg.
REQ-039 SHALL implement the buffer as one sub-module, pg_pattern_ram (1 write port, 1 synchronous read port, 1-cycle latency, inferable BRAM).

Verification
REQ-040 SHALL cover: words {0x6,0x5,0x3}, num_words=3, clk_div=3 -> each value held 4 cycles, 3 pg_clk pulses, done at cycle 2+12, pg_scl=3'b111 after.
REQ-041 SHALL cover: word 2 has bit31 set, num_words=10 -> exactly 3 steps, done pulse.
REQ-042 SHALL cover: stop in step 2 of 5 -> next cycle pg_scl=3'b111, busy=0, done never asserts.
REQ-043 SHALL cover: num_words=0 -> done 2 cycles after start, no pg_clk; start+stop in the same cycle -> busy stays 0.
REQ-044 SHALL cover: rst during RUN -> all outputs at reset values the next cycle, and a subsequent start replays the unchanged buffer.
REQ-045 SHALL cover (PG_CAPTURE_EN): 4 steps with bit30=1, scl_in[0]=1,0,1,1 -> cap_data=0xD, cap_cnt=4.
